// File: rtl/lfp_requant_e4m4_to_e3m4.sv
// ---------------------------------------------------------------------------
// lfp_requant_e4m4_to_e3m4
// Re-quantises an E4M4 word (4-bit exponent, 4-bit mantissa) to E3M4.
// Exponents above the output range clamp to 7'h7F and raise out_sat.
// Exponents below the output range flush to 7'h00 and raise out_flush.
// Two-stage valid/ready pipeline with one word per cycle throughput.
// Optional feature macro: LFP_REQUANT_SAT_COUNT_EN enables the saturating
// sat_cnt / flush_cnt event counters. Without it both read 0 and clr_cnt is
// ignored.
// ---------------------------------------------------------------------------
module lfp_requant_e4m4_to_e3m4 #(
   parameter int BIAS_IN  = 8,
   parameter int BIAS_OUT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [6:0]  out_data,
   output logic        out_sat,
   output logic        out_flush,
   input  logic        clr_cnt,
   output logic [15:0] sat_cnt,
   output logic [15:0] flush_cnt
);

   // Bias difference; the range -15..7 fits a 6-bit signed value.
   localparam logic signed [5:0] L_BIAS_DELTA = 6'(BIAS_OUT - BIAS_IN);

   // Packs {sat, flush, data} for a rebased exponent and a mantissa.
   function automatic logic [8:0] f_requant(input logic signed [5:0] exp_v,
                                             input logic [3:0]        man_v);
      logic [8:0] res;
      if (exp_v < 6'sd0) begin
         res = {1'b0, 1'b1, 7'h00};
      end else if (exp_v > 6'sd7) begin
         res = {1'b1, 1'b0, 7'h7F};
      end else begin
         res = {1'b0, 1'b0, exp_v[2:0], man_v};
      end
      return res;
   endfunction

   logic               r_s1_valid;
   logic signed [5:0]  r_s1_exp;
   logic [3:0]         r_s1_man;
   logic               r_s2_valid;
   logic [6:0]         r_s2_data;
   logic               r_s2_sat;
   logic               r_s2_flush;

   logic               w_s2_advance;
   logic               w_in_ready;
   logic signed [5:0]  w_exp;
   logic [8:0]         w_packed;

   // Stage 2 can take a new word when it is empty or being drained.
   // Ein (0..15) plus the bias delta spans -15..22, so 6 signed bits never truncate.
   assign w_s2_advance = !r_s2_valid || out_ready;
   assign w_in_ready   = !r_s1_valid || w_s2_advance;
   assign w_exp        = $signed({2'b00, in_data[7:4]}) + L_BIAS_DELTA;
   assign w_packed     = f_requant(r_s1_exp, r_s1_man);

   // Stage 1: capture the rebased exponent, mantissa and valid bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_exp   <= 6'sd0;
         r_s1_man   <= 4'h0;
      end else if (w_in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_exp <= w_exp;
            r_s1_man <= in_data[3:0];
         end
      end
   end

   // Stage 2: register the packed result; hold it while the sink stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= 7'h00;
         r_s2_sat   <= 1'b0;
         r_s2_flush <= 1'b0;
      end else if (w_s2_advance) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_sat   <= w_packed[8];
            r_s2_flush <= w_packed[7];
            r_s2_data  <= w_packed[6:0];
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_s2_valid;
   assign out_data  = r_s2_data;
   assign out_sat   = r_s2_sat;
   assign out_flush = r_s2_flush;

`ifdef LFP_REQUANT_SAT_COUNT_EN
   logic [15:0] r_sat_cnt;
   logic [15:0] r_flush_cnt;
   logic        w_deliver;

   assign w_deliver = r_s2_valid && out_ready;

   // Saturating delivery counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sat_cnt   <= 16'h0000;
         r_flush_cnt <= 16'h0000;
      end else if (clr_cnt) begin
         r_sat_cnt   <= 16'h0000;
         r_flush_cnt <= 16'h0000;
      end else begin
         if (w_deliver && r_s2_sat && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'h0001;
         end
         if (w_deliver && r_s2_flush && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'h0001;
         end
      end
   end

   assign sat_cnt   = r_sat_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   logic w_unused_clr_cnt;

   assign w_unused_clr_cnt = clr_cnt;
   assign sat_cnt          = 16'h0000;
   assign flush_cnt        = 16'h0000;
`endif

endmodule

// File: tb/tb_lfp_requant_e4m4_to_e3m4.sv
// ---------------------------------------------------------------------------
// Bench for lfp_requant_e4m4_to_e3m4 with default biases (8 in, 4 out).
// Directed vector table, backpressure stream, random handshake run,
// mid-flight reset and (with LFP_REQUANT_SAT_COUNT_EN) counter checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lfp_requant_e4m4_to_e3m4;

   typedef struct {
      logic [7:0] din;
      logic [6:0] dout;
      logic       sat;
      logic       flush;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_data;
   logic        out_sat;
   logic        out_flush;
   logic        clr_cnt;
   logic [15:0] sat_cnt;
   logic [15:0] flush_cnt;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [8:0]  exp_q[$];
   logic [6:0]  got_q[$];
   bit          rnd_done;
   vec_t        vecs[10];

   lfp_requant_e4m4_to_e3m4 #(.BIAS_IN(8), .BIAS_OUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .out_flush(out_flush),
      .clr_cnt(clr_cnt), .sat_cnt(sat_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: e = Ein - 8 + 4, returns {sat, flush, data}.
   function automatic logic [8:0] model(input logic [7:0] d);
      int e;
      logic [8:0] r;
      logic [6:0] w;
      e = int'(d[7:4]) - 8 + 4;
      if (e > 7)      r = {1'b1, 1'b0, 7'h7F};
      else if (e < 0) r = {1'b0, 1'b1, 7'h00};
      else begin
         w = 7'(e * 16) | {3'b000, d[3:0]};
         r = {2'b00, w};
      end
      return r;
   endfunction

   // Offer one word and hold it until accepted; returns 1 ns after the accept edge.
   task automatic send(input logic [7:0] d);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready stuck at 0 for word %0h", d);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Scoreboard / stall-stability monitor, sampled on the falling edge.
   initial begin
      logic       prev_stall;
      logic [8:0] prev_word;
      logic [8:0] e;
      prev_stall = 1'b0;
      prev_word  = 9'h000;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_word", 32'({out_sat, out_flush, out_data}), 32'(prev_word));
            end
            if (out_valid === 1'b1)
               check("sat_flush_excl", 32'(out_sat & out_flush), 32'd0);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               got_q.push_back(out_data);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL sb_unexpected: got %0h, expected no word", out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_word", 32'({out_sat, out_flush, out_data}), 32'(e));
               end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1)
               exp_q.push_back(model(in_data));
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_word  = {out_sat, out_flush, out_data};
         end
      end
   end

   initial begin
      vecs[0] = '{8'h9A, 7'h5A, 1'b0, 1'b0};
      vecs[1] = '{8'h4F, 7'h0F, 1'b0, 1'b0};
      vecs[2] = '{8'hBF, 7'h7F, 1'b0, 1'b0};
      vecs[3] = '{8'hC3, 7'h7F, 1'b1, 1'b0};
      vecs[4] = '{8'h35, 7'h00, 1'b0, 1'b1};
      vecs[5] = '{8'h00, 7'h00, 1'b0, 1'b1};
      vecs[6] = '{8'h80, 7'h40, 1'b0, 1'b0};
      vecs[7] = '{8'hFF, 7'h7F, 1'b1, 1'b0};
      vecs[8] = '{8'h40, 7'h00, 1'b0, 1'b0};
      vecs[9] = '{8'h3F, 7'h00, 1'b0, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;
      rnd_done  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      check("rst_out_flush", 32'(out_flush), 32'd0);
      check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
      check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);

      // Directed table: each word appears two edges after its accept edge.
      for (int i = 0; i < 10; i++) begin
         send(vecs[i].din);
         check("tbl_not_yet_valid", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
         check("tbl_valid", 32'(out_valid), 32'd1);
         check("tbl_data", 32'(out_data), 32'(vecs[i].dout));
         check("tbl_sat", 32'(out_sat), 32'(vecs[i].sat));
         check("tbl_flush", 32'(out_flush), 32'(vecs[i].flush));
      end
      @(posedge clk);
      #1;

      // Backpressure: stream 90..9F with a 5-cycle sink stall mid-stream.
      got_q.delete();
      fork
         begin
            for (int i = 0; i < 16; i++) send(8'(8'h90 + i));
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      for (int k = 0; k < 50 && got_q.size() < 16; k++) @(negedge clk);
      check("bp_count", 32'(got_q.size()), 32'd16);
      for (int i = 0; i < 16 && i < got_q.size(); i++)
         check("bp_order", 32'(got_q[i]), 32'(7'h50 + 7'(i)));

      // Random valid/ready toggling, 1000 words.
      fork
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send(8'($urandom));
      end
      rnd_done = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
      check("rnd_drained", 32'(exp_q.size()), 32'd0);

      // Reset with two words in flight.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(8'h91);
      send(8'h92);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("midrst_no_stale", 32'(out_valid), 32'd0);
      end

`ifdef LFP_REQUANT_SAT_COUNT_EN
      // Counters: preload sat_cnt to FFFE, then 3 more, then clear during a delivery.
      @(posedge clk);
      #1;
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
      check("cnt_cleared", 32'(sat_cnt), 32'd0);
      got_q.delete();
      for (int i = 0; i < 65534; i++) send(8'hC3);
      repeat (3) @(posedge clk);
      #1;
      check("cnt_preload", 32'(sat_cnt), 32'h0000FFFE);
      got_q.delete();
      for (int i = 0; i < 3; i++) send(8'hC3);
      repeat (3) @(posedge clk);
      #1;
      check("cnt_saturate", 32'(sat_cnt), 32'h0000FFFF);
      send(8'h00);
      repeat (3) @(posedge clk);
      #1;
      check("flush_cnt_one", 32'(flush_cnt), 32'd1);
      send(8'hC3);
      @(posedge clk);
      #1;
      check("clr_pair_valid", 32'(out_valid), 32'd1);
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
      check("clr_priority_sat", 32'(sat_cnt), 32'd0);
      check("clr_priority_flush", 32'(flush_cnt), 32'd0);
`else
      check("cnt_tied_sat", 32'(sat_cnt), 32'd0);
      check("cnt_tied_flush", 32'(flush_cnt), 32'd0);
`endif

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lfp_requant_e4m4_to_e3m4.md
LFP_REQUANT_E4M4_TO_E3M4 -- requirements
Module: lfp_requant_e4m4_to_e3m4

Interface
REQ-001 SHALL have parameter BIAS_IN, default 8, exponent bias of the E4M4 input; legal range 0..15.
REQ-002 SHALL have parameter BIAS_OUT, default 4, exponent bias of the E3M4 output; legal range 0..7.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  8  E4M4 word: exponent [7:4], mantissa [3:0].
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts output this cycle.
- out_data  out  7  E3M4 word: exponent [6:4], mantissa [3:0].
- out_sat  out  1  out_data was clamped to maximum.
- out_flush  out  1  out_data was flushed to zero.
- clr_cnt  in  1  synchronous counter clear.
- sat_cnt  out  16  count of saturated outputs delivered.
- flush_cnt  out  16  count of flushed outputs delivered.

Function
REQ-004 SHALL compute e = Ein - BIAS_IN + BIAS_OUT as a signed value of at least 6 bits; Ein = in_data[7:4]; no intermediate truncation.
REQ-005 SHALL, for 0 <= e <= 7, set out_data = {e[2:0], in_data[3:0]}, with out_sat = 0 and out_flush = 0.
REQ-006 SHALL, for e > 7, set out_data = 7'h7F and out_sat = 1 (saturation); mantissa is discarded.
REQ-007 SHALL, for e < 0, set out_data = 7'h00 and out_flush = 1 (flush to zero); mantissa is discarded.
REQ-008 SHALL never assert out_sat and out_flush together.
REQ-009 SHALL be a 2-stage pipeline:
- stage 1 registers e, mantissa and the valid bit.
- stage 2 registers the packed out_data, out_sat, out_flush and out_valid.
REQ-010 SHALL, with out_ready held high, present a word on out_data 2 cycles after the in_valid & in_ready edge; throughput 1 word/cycle.
REQ-011 SHALL transfer a word only on a cycle where valid and ready are both high, on each side.
REQ-012 SHALL hold out_valid, out_data, out_sat and out_flush stable while out_valid=1 and out_ready=0.
REQ-013 SHALL drive in_ready = !s1_valid | s2_advance, where s2_advance = !out_valid | out_ready; in_ready has no combinational dependence on in_valid.
REQ-014 SHALL neither lose nor duplicate a word under any valid/ready pattern; order is preserved.
REQ-015 SHALL handle accept-and-deliver in the same cycle with both pipeline stages full and out_ready=1 without a bubble.

Reset
REQ-016 SHALL, on a clk edge with rst_n=0, clear the stage-1 valid bit and the stage-2 valid bit, and drive out_valid=0, out_data=0, out_sat=0, out_flush=0, sat_cnt=0 and flush_cnt=0.
REQ-017 SHALL drive in_ready=1 in the cycle after reset release.
REQ-018 SHALL discard any word in flight when reset is asserted mid-operation, with no output after release.

Configuration
REQ-019 SHALL implement the event counters only when macro LFP_REQUANT_SAT_COUNT_EN is defined.
REQ-020 SHALL, with LFP_REQUANT_SAT_COUNT_EN defined, behave as follows:
- sat_cnt increments by 1 on each cycle with out_valid & out_ready & out_sat.
- flush_cnt increments by 1 on each cycle with out_valid & out_ready & out_flush.
- Both counters saturate at 16'hFFFF and do not wrap.
- clr_cnt=1 zeroes both counters and takes priority over a same-cycle increment.
REQ-021 SHALL, without LFP_REQUANT_SAT_COUNT_EN, keep all ports present, tie sat_cnt and flush_cnt to 0, ignore clr_cnt and instantiate no counter flops; out_sat and out_flush remain functional.

Verification
REQ-022 SHALL cover, with default parameters and out_ready=1:
- in_data 8'h9A -> out_data 7'h5A, out_sat=0, out_flush=0, 2 cycles later.
- 8'h4F -> 7'h0F (e=0 boundary, no flush).
- 8'hBF -> 7'h7F with out_sat=0 (e=7 boundary).
REQ-023 SHALL cover out-of-range inputs:
- in_data 8'hC3 -> 7'h7F with out_sat=1.
- in_data 8'h35 -> 7'h00 with out_flush=1.
- in_data 8'h00 -> 7'h00 with out_flush=1.
REQ-024 SHALL cover backpressure:
- Stream 8'h90..8'h9F with out_ready low for 5 cycles mid-stream.
- in_ready deasserts once both stages are full.
- Outputs 7'h50..7'h5F arrive in order, none lost or duplicated, held stable while stalled.
REQ-025 SHALL cover randomized valid/ready toggling for 1000 words, checked against a reference model of REQ-004..REQ-007 with zero mismatches.
REQ-026 SHALL cover reset mid-operation: assert rst_n=0 with 2 words in flight -> out_valid=0 next cycle and no stale word after release.
REQ-027 SHALL, with LFP_REQUANT_SAT_COUNT_EN defined, cover the counters:
- Preload sat_cnt to 16'hFFFE via 2^16-2 saturating words, deliver 3 more -> sat_cnt=16'hFFFF.
- Then assert clr_cnt together with a saturating delivery -> sat_cnt=0.
